// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART receive and transmit sides.
// Holds the receiver state encoding and the default framing parameters
// so both directions agree on oversampling rate and word length.
package uart_pkg;

  // Default sample ticks per bit period.
  localparam int UART_OVERSAMPLE = 16;

  // Default number of data bits per frame, sent LSB first.
  localparam int UART_DATA_BITS = 8;

  // Receiver states. A frame walks IDLE -> START -> DATA -> STOP -> IDLE.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage : uart_pkg

// File: rtl/uart_rx_sync.sv
// uart_rx_sync
// Two-flop synchronizer that brings the asynchronous serial line into the
// clk domain. Both flops reset to 1 so that the idle-high line does not
// look like a start bit while reset is released.
//
// Ports
//   clk     system clock
//   rst     synchronous, active-high reset
//   async_i asynchronous serial input
//   sync_o  synchronized copy of async_i, two clk cycles late
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  // The first flop may go metastable; only the second flop is used.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule : uart_rx_sync

// File: rtl/uart_rx.sv
// uart_rx
// Oversampling UART receiver. Finds the start bit's falling edge, confirms
// it at the middle of the start bit, then samples each data bit and the
// stop bit at their mid-points. Good frames update data_out_o with a
// one-clk data_valid_o pulse; a low stop bit gives a one-clk frame_err_o
// pulse and leaves data_out_o untouched.
//
// Ports
//   clk          system clock, all logic on posedge
//   rst          synchronous, active-high reset
//   tick_i       one-clk strobe at OVERSAMPLE x baud rate
//   rx_i         asynchronous serial line, idles high
//   data_out_o   last correctly framed word, held until the next good frame
//   data_valid_o one-clk pulse when data_out_o updates
//   frame_err_o  one-clk pulse when the stop bit is sampled low
//   busy_o       high from start-bit detection until return to IDLE
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int DATA_BITS  = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick_i,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] data_out_o,
  output logic                 data_valid_o,
  output logic                 frame_err_o,
  output logic                 busy_o
);

  localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  // Last tick count of half a bit (start confirm) and of a full bit.
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  logic                 rx_s;

  uart_state_e          state_q,    state_d;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]        bit_cnt_q,  bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q,    shift_d;
  logic [DATA_BITS-1:0] data_q,     data_d;
  logic                 valid_q,    valid_d;
  logic                 ferr_q,     ferr_d;

  uart_rx_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (rx_i),
    .sync_o  (rx_s)
  );

  // State register. Reset has priority over a coincident tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
    end
  end

  // Next-state logic. Nothing moves except on a tick, so the pulse
  // defaults of zero make data_valid/frame_err exactly one clk wide.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    ferr_d     = 1'b0;

    if (tick_i) begin
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_d    = START;
            tick_cnt_d = '0;
          end
        end

        // A start bit that is no longer low at its mid-point is a glitch.
        START: begin
          if (tick_cnt_q == HALF_LAST) begin
            tick_cnt_d = '0;
            if (!rx_s) begin
              state_d   = DATA;
              bit_cnt_d = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end

        // From the start mid-point, every full bit lands on a data mid-point.
        DATA: begin
          if (tick_cnt_q == FULL_LAST) begin
            shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
            tick_cnt_d = '0;
            bit_cnt_d  = bit_cnt_q + BW'(1);
            if (bit_cnt_q == BIT_LAST) begin
              state_d = STOP;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end

        // Leaving at the stop mid-point gives half a bit of slack to catch
        // a back-to-back start edge.
        STOP: begin
          if (tick_cnt_q == FULL_LAST) begin
            tick_cnt_d = '0;
            state_d    = IDLE;
            if (rx_s) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ferr_d = 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end

        default: begin
          state_d    = IDLE;
          tick_cnt_d = '0;
        end
      endcase
    end
  end

  assign data_out_o   = data_q;
  assign data_valid_o = valid_q;
  assign frame_err_o  = ferr_q;
  assign busy_o       = (state_q != IDLE);

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// tb_uart_rx
// Directed testbench for uart_rx at 16x oversampling, 8 data bits.
// The tick strobe fires every 4 clk, so one bit period is 64 clk.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;

  logic tick_en = 1'b0;
  int   div_cnt = 0;

  int         dv_cnt = 0;
  int         fe_cnt = 0;
  logic [7:0] dv_data [$];
  logic       prev_dv = 1'b0;
  logic       prev_fe = 1'b0;

  uart_rx #(
    .OVERSAMPLE (16),
    .DATA_BITS  (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tick_i       (tick),
    .rx_i         (rx),
    .data_out_o   (data_out),
    .data_valid_o (data_valid),
    .frame_err_o  (frame_err),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  // Tick strobe: one clk high out of every four while enabled.
  always @(posedge clk) begin
    if (tick_en) begin
      if (div_cnt == 3) begin
        div_cnt <= 0;
        tick    <= 1'b1;
      end else begin
        div_cnt <= div_cnt + 1;
        tick    <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

  // Pulse monitor: records every data_valid word and frame_err, and checks
  // that pulses are exclusive and one clk wide.
  always @(negedge clk) begin
    if (!rst && (data_valid || frame_err)) begin
      vectors++;
      if ((data_valid && frame_err) || (data_valid && prev_dv) || (frame_err && prev_fe)) begin
        miscompares++;
        $display("[TB] FAIL pulse_shape: valid=%0b err=%0b prev_valid=%0b prev_err=%0b, required single exclusive pulse",
                 data_valid, frame_err, prev_dv, prev_fe);
      end
      if (data_valid) begin
        dv_cnt++;
        dv_data.push_back(data_out);
      end
      if (frame_err) fe_cnt++;
    end
    prev_dv = data_valid;
    prev_fe = frame_err;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic wait_ticks(input int n);
    int seen;
    int guard;
    seen  = 0;
    guard = 0;
    while (seen < n) begin
      @(posedge clk);
      if (tick) seen++;
      guard++;
      if (guard > n * 8 + 400) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL tick_wait: saw %0d ticks, required %0d", seen, n);
        break;
      end
    end
    #1;
  endtask

  task automatic drive_bit(input logic v, input int n);
    rx = v;
    wait_ticks(n);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    drive_bit(1'b0, 16);
    for (int i = 0; i < 8; i++) drive_bit(b[i], 16);
    drive_bit(stop_bit, 16);
    rx = 1'b1;
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    tick_en = 1'b1;
    rx      = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_busy: got %0b, required 0", busy);
    end
    vectors++;
    if (data_out !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL reset_data: got %02h, required 00", data_out);
    end
    vectors++;
    if (data_valid !== 1'b0 || frame_err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_pulses: valid=%0b err=%0b, required 0 0", data_valid, frame_err);
    end
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    wait_ticks(4);
    vectors++;
    if (busy !== 1'b0 || dv_cnt !== 0 || fe_cnt !== 0) begin
      miscompares++;
      $display("[TB] FAIL reset_release: busy=%0b valid_cnt=%0d err_cnt=%0d, required 0 0 0",
               busy, dv_cnt, fe_cnt);
    end
  endtask

  task automatic test_good_frame();
    int dv0;
    int fe0;
    logic [7:0] b;
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    b   = 8'hA5;
    drive_bit(1'b0, 16);
    for (int i = 0; i < 8; i++) drive_bit(b[i], 16);
    drive_bit(1'b1, 4);
    vectors++;
    if (busy !== 1'b1 || dv_cnt !== dv0) begin
      miscompares++;
      $display("[TB] FAIL a5_before_stop: busy=%0b valid_cnt=%0d, required 1 %0d", busy, dv_cnt, dv0);
    end
    drive_bit(1'b1, 12);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL a5_busy_end: got %0b, required 0", busy);
    end
    vectors++;
    if (dv_cnt !== dv0 + 1 || fe_cnt !== fe0) begin
      miscompares++;
      $display("[TB] FAIL a5_pulses: valid_cnt=%0d err_cnt=%0d, required %0d %0d",
               dv_cnt, fe_cnt, dv0 + 1, fe0);
    end
    vectors++;
    if (data_out !== 8'hA5) begin
      miscompares++;
      $display("[TB] FAIL a5_data: got %02h, required a5", data_out);
    end
    drive_bit(1'b1, 8);
  endtask

  task automatic test_glitch();
    int dv0;
    int fe0;
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    drive_bit(1'b0, 4);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL glitch_busy_high: got %0b, required 1", busy);
    end
    drive_bit(1'b1, 12);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL glitch_busy_low: got %0b, required 0", busy);
    end
    vectors++;
    if (dv_cnt !== dv0 || fe_cnt !== fe0 || data_out !== 8'hA5) begin
      miscompares++;
      $display("[TB] FAIL glitch_no_pulse: valid_cnt=%0d err_cnt=%0d data=%02h, required %0d %0d a5",
               dv_cnt, fe_cnt, data_out, dv0, fe0);
    end
    drive_bit(1'b1, 8);
  endtask

  task automatic test_frame_error();
    int dv0;
    int fe0;
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0);
    drive_bit(1'b1, 32);
    vectors++;
    if (fe_cnt !== fe0 + 1 || dv_cnt !== dv0) begin
      miscompares++;
      $display("[TB] FAIL ferr_pulses: err_cnt=%0d valid_cnt=%0d, required %0d %0d",
               fe_cnt, dv_cnt, fe0 + 1, dv0);
    end
    vectors++;
    if (data_out !== 8'hA5) begin
      miscompares++;
      $display("[TB] FAIL ferr_data_held: got %02h, required a5", data_out);
    end
  endtask

  task automatic test_back_to_back();
    int dv0;
    int fe0;
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    drive_bit(1'b1, 16);
    vectors++;
    if (dv_cnt !== dv0 + 2 || fe_cnt !== fe0) begin
      miscompares++;
      $display("[TB] FAIL b2b_pulses: valid_cnt=%0d err_cnt=%0d, required %0d %0d",
               dv_cnt, fe_cnt, dv0 + 2, fe0);
    end else begin
      vectors++;
      if (dv_data[dv0] !== 8'h00 || dv_data[dv0 + 1] !== 8'hFF) begin
        miscompares++;
        $display("[TB] FAIL b2b_data: got %02h %02h, required 00 ff", dv_data[dv0], dv_data[dv0 + 1]);
      end
    end
    vectors++;
    if (data_out !== 8'hFF) begin
      miscompares++;
      $display("[TB] FAIL b2b_final: got %02h, required ff", data_out);
    end
  endtask

  task automatic test_reset_mid_frame();
    int dv0;
    logic [7:0] b;
    dv0 = dv_cnt;
    b   = 8'h5A;
    drive_bit(1'b0, 16);
    for (int i = 0; i < 4; i++) drive_bit(b[i], 16);
    drive_bit(b[4], 8);
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0 || data_out !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL rst_mid_state: busy=%0b data=%02h, required 0 00", busy, data_out);
    end
    rst = 1'b0;
    drive_bit(1'b1, 24);
    vectors++;
    if (dv_cnt !== dv0 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL rst_mid_abandon: valid_cnt=%0d busy=%0b, required %0d 0", dv_cnt, busy, dv0);
    end
    send_frame(8'h81, 1'b1);
    drive_bit(1'b1, 8);
    vectors++;
    if (dv_cnt !== dv0 + 1 || data_out !== 8'h81) begin
      miscompares++;
      $display("[TB] FAIL rst_mid_next: valid_cnt=%0d data=%02h, required %0d 81", dv_cnt, data_out, dv0 + 1);
    end
  endtask

  task automatic test_tick_pause();
    int dv0;
    int fe0;
    int busy_changes;
    logic [7:0] b;
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    b   = 8'h96;
    busy_changes = 0;
    drive_bit(1'b0, 16);
    for (int i = 0; i < 3; i++) drive_bit(b[i], 16);
    drive_bit(b[3], 8);
    tick_en = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (busy !== 1'b1) busy_changes++;
    end
    vectors++;
    if (busy_changes !== 0 || dv_cnt !== dv0 || fe_cnt !== fe0) begin
      miscompares++;
      $display("[TB] FAIL pause_hold: busy_low_cycles=%0d valid_cnt=%0d err_cnt=%0d, required 0 %0d %0d",
               busy_changes, dv_cnt, fe_cnt, dv0, fe0);
    end
    @(posedge clk);
    #1;
    tick_en = 1'b1;
    wait_ticks(8);
    for (int i = 4; i < 8; i++) drive_bit(b[i], 16);
    drive_bit(1'b1, 16);
    drive_bit(1'b1, 8);
    vectors++;
    if (dv_cnt !== dv0 + 1 || fe_cnt !== fe0 || data_out !== 8'h96) begin
      miscompares++;
      $display("[TB] FAIL pause_frame: valid_cnt=%0d err_cnt=%0d data=%02h, required %0d %0d 96",
               dv_cnt, fe_cnt, data_out, dv0 + 1, fe0);
    end
  endtask

  initial begin
    $display("[TB] uart_rx directed test start");
    test_reset();
    test_good_frame();
    test_glitch();
    test_frame_error();
    test_back_to_back();
    test_reset_mid_frame();
    test_tick_pause();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_uart_rx
